// File: rtl/teclado_pkg.sv
// Shared keypad definitions: key codes and entry FSM states.
// Imported by the keypad scanner and by acumulador_teclado.
package teclado_pkg;

  localparam logic [3:0] TECLA_C         = 4'hC;
  localparam logic [3:0] TECLA_ASTERISCO = 4'hE;
  localparam logic [3:0] TECLA_CERQUILHA = 4'hF;

  typedef enum logic [1:0] {
    ESPERA,
    ENTRADA,
    CONFIRMA
  } estado_t;

  function automatic logic eh_digito(
    input logic [3:0] k
  );
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/detector_borda.sv
// Rising-edge detector; after reset it must first see the input low
// before it can fire, so a key held through reset produces no event.
module detector_borda (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic r_prev;
  logic r_armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_prev <= in;
      if (!in) r_armed <= 1'b1;
    end
  end

  assign pulse = in & ~r_prev & r_armed;

endmodule

// File: rtl/acumulador_teclado.sv
// Keypad digit accumulator with commit, clear and idle timeout.
// Define ACUM_BACKSPACE_EN to make key C delete the newest digit.
module acumulador_teclado
  import teclado_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    bcd_in,
  input  logic                          key_valid_in,
  output logic [4*N_DIGITS-1:0]         digitos_out,
  output logic [$clog2(N_DIGITS+1)-1:0] contagem_out,
  output logic [4*N_DIGITS-1:0]         valor_out,
  output logic                          valor_valid,
  output logic                          erro
);

  localparam int DW = 4 * N_DIGITS;
  localparam int CW = $clog2(N_DIGITS + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CMAX = CW'(N_DIGITS);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

  estado_t r_estado, w_estado;
  logic [DW-1:0] r_dig, w_dig;
  logic [CW-1:0] r_cont, w_cont;
  logic [DW-1:0] r_valor, w_valor;
  logic [TW-1:0] r_idle, w_idle;
  logic          r_valid, w_valid;
  logic          r_erro, w_erro;

  logic w_evt;
  logic w_num;
  logic w_ast;
  logic w_cer;
  logic w_bs;

  detector_borda u_borda (
    .clk   (clk),
    .rst   (rst),
    .in    (key_valid_in),
    .pulse (w_evt)
  );

  assign w_num = eh_digito(bcd_in);
  assign w_ast = (bcd_in == TECLA_ASTERISCO);
  assign w_cer = (bcd_in == TECLA_CERQUILHA);
`ifdef ACUM_BACKSPACE_EN
  assign w_bs = (bcd_in == TECLA_C);
`else
  assign w_bs = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado <= ESPERA;
      r_dig    <= '0;
      r_cont   <= '0;
      r_valor  <= '0;
      r_idle   <= '0;
      r_valid  <= 1'b0;
      r_erro   <= 1'b0;
    end else begin
      r_estado <= w_estado;
      r_dig    <= w_dig;
      r_cont   <= w_cont;
      r_valor  <= w_valor;
      r_idle   <= w_idle;
      r_valid  <= w_valid;
      r_erro   <= w_erro;
    end
  end

  // CONFIRMA lasts one cycle; events seen there are handled like ESPERA
  always_comb begin
    w_estado = (r_estado == CONFIRMA) ? ESPERA : r_estado;
    w_dig    = r_dig;
    w_cont   = r_cont;
    w_valor  = r_valor;
    w_idle   = '0;
    w_valid  = 1'b0;
    w_erro   = 1'b0;
    if (w_evt) begin
      unique case (1'b1)
        w_num: begin
          if (r_cont < CMAX) begin
            w_dig    = (r_dig << 4) | DW'(bcd_in);
            w_cont   = r_cont + CW'(1);
            w_estado = ENTRADA;
          end else begin
            w_erro = 1'b1;
          end
        end
        w_ast: begin
          w_dig    = '0;
          w_cont   = '0;
          w_estado = ESPERA;
        end
        w_cer: begin
          if (r_cont != '0) begin
            w_valor  = r_dig;
            w_valid  = 1'b1;
            w_dig    = '0;
            w_cont   = '0;
            w_estado = CONFIRMA;
          end else begin
            w_erro = 1'b1;
          end
        end
        w_bs: begin
          if (r_cont != '0) begin
            w_dig    = r_dig >> 4;
            w_cont   = r_cont - CW'(1);
            w_estado = (r_cont == CW'(1)) ? ESPERA : ENTRADA;
          end else begin
            w_erro = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (r_estado == ENTRADA) begin
      if (r_idle == TLAST) begin
        w_dig    = '0;
        w_cont   = '0;
        w_erro   = 1'b1;
        w_estado = ESPERA;
      end else begin
        w_idle = r_idle + TW'(1);
      end
    end
  end

  assign digitos_out  = r_dig;
  assign contagem_out = r_cont;
  assign valor_out    = r_valor;
  assign valor_valid  = r_valid;
  assign erro         = r_erro;

endmodule

// File: tb/tb_acumulador_teclado.sv
// Directed bench for acumulador_teclado; a second instance with a
// short timeout covers idle expiry. Expectations follow ACUM_BACKSPACE_EN.
module tb_acumulador_teclado;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  bcd = 4'h0;
  logic        key = 1'b0;

  logic [15:0] dig, val;
  logic [2:0]  cnt;
  logic        vv, er;
  logic [15:0] dig_t, val_t;
  logic [2:0]  cnt_t;
  logic        vv_t, er_t;

  int checks = 0;
  int passed = 0;
  int n_vv = 0;
  int n_er = 0;
  int vv0, er0;

  always #5 clk = ~clk;

  acumulador_teclado #(
    .N_DIGITS    (4),
    .TIMEOUT_CYC (5000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bcd_in       (bcd),
    .key_valid_in (key),
    .digitos_out  (dig),
    .contagem_out (cnt),
    .valor_out    (val),
    .valor_valid  (vv),
    .erro         (er)
  );

  acumulador_teclado #(
    .N_DIGITS    (4),
    .TIMEOUT_CYC (20)
  ) dut_t (
    .clk          (clk),
    .rst          (rst),
    .bcd_in       (bcd),
    .key_valid_in (key),
    .digitos_out  (dig_t),
    .contagem_out (cnt_t),
    .valor_out    (val_t),
    .valor_valid  (vv_t),
    .erro         (er_t)
  );

  always @(posedge clk) begin
    if (vv) n_vv <= n_vv + 1;
    if (er) n_er <= n_er + 1;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // called on a negedge; returns two negedges later
  task automatic press(input logic [3:0] k);
    bcd = k;
    key = 1'b1;
    @(negedge clk);
    key = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    key = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_dig", 32'(dig), 32'h0);
    chk("rst_cnt", 32'(cnt), 32'h0);
    chk("rst_val", 32'(val), 32'h0);
    chk("rst_vv", 32'(vv), 32'h0);
    chk("rst_er", 32'(er), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    vv0 = n_vv;
    er0 = n_er;
    press(4'h1);
    press(4'h2);
    press(4'h3);
    chk("t1_dig", 32'(dig), 32'h0123);
    chk("t1_cnt", 32'(cnt), 32'd3);
    press(4'hF);
    chk("t1_val", 32'(val), 32'h0123);
    chk("t1_vv1", 32'(n_vv - vv0), 32'd1);
    chk("t1_cnt0", 32'(cnt), 32'd0);
    chk("t1_dig0", 32'(dig), 32'h0);
    chk("t1_er", 32'(n_er - er0), 32'd0);

    bcd = 4'h5;
    key = 1'b1;
    repeat (50) @(negedge clk);
    chk("t2_dig", 32'(dig), 32'h0005);
    chk("t2_cnt", 32'(cnt), 32'd1);
    key = 1'b0;
    repeat (2) @(negedge clk);
    chk("t2_cnt_rel", 32'(cnt), 32'd1);
    press(4'hE);
    chk("t2_clr", 32'(cnt), 32'd0);

    press(4'h1);
    press(4'h2);
    press(4'h3);
    press(4'h4);
    chk("t3_dig4", 32'(dig), 32'h1234);
    chk("t3_cnt4", 32'(cnt), 32'd4);
    er0 = n_er;
    press(4'h5);
    chk("t3_er", 32'(n_er - er0), 32'd1);
    chk("t3_dig", 32'(dig), 32'h1234);
    press(4'hF);
    chk("t3_val", 32'(val), 32'h1234);
    chk("t3_cnt0", 32'(cnt), 32'd0);

    vv0 = n_vv;
    er0 = n_er;
    press(4'h7);
    press(4'hE);
    chk("t4_dig", 32'(dig), 32'h0);
    chk("t4_cnt", 32'(cnt), 32'd0);
    chk("t4_vv", 32'(n_vv - vv0), 32'd0);
    chk("t4_er0", 32'(n_er - er0), 32'd0);
    press(4'hF);
    chk("t4_er1", 32'(n_er - er0), 32'd1);
    chk("t4_val", 32'(val), 32'h1234);
    chk("t4_vv0", 32'(n_vv - vv0), 32'd0);

    press(4'hA);
    press(4'hB);
    press(4'hD);
    chk("ign_cnt", 32'(cnt), 32'd0);
    chk("ign_er", 32'(n_er - er0), 32'd1);

    do_reset();
    press(4'h9);
    repeat (18) @(negedge clk);
    chk("to_pre_er", 32'(er_t), 32'h0);
    chk("to_pre_dig", 32'(dig_t), 32'h0009);
    @(negedge clk);
    chk("to_er", 32'(er_t), 32'h1);
    chk("to_dig", 32'(dig_t), 32'h0);
    chk("to_cnt", 32'(cnt_t), 32'd0);

    do_reset();
    press(4'h9);
    repeat (18) @(negedge clk);
    bcd = 4'h8;
    key = 1'b1;
    @(negedge clk);
    chk("tc_er", 32'(er_t), 32'h0);
    chk("tc_dig", 32'(dig_t), 32'h0098);
    key = 1'b0;
    @(negedge clk);
    chk("tc_er2", 32'(er_t), 32'h0);
    chk("tc_cnt", 32'(cnt_t), 32'd2);

    do_reset();
    press(4'h4);
    press(4'h5);
    press(4'hC);
`ifdef ACUM_BACKSPACE_EN
    chk("bs_dig", 32'(dig), 32'h0004);
    chk("bs_cnt", 32'(cnt), 32'd1);
`else
    chk("bs_dig", 32'(dig), 32'h0045);
    chk("bs_cnt", 32'(cnt), 32'd2);
`endif

    do_reset();
    press(4'h1);
    press(4'h2);
    rst = 1'b1;
    bcd = 4'h6;
    key = 1'b1;
    @(negedge clk);
    chk("rd_dig", 32'(dig), 32'h0);
    chk("rd_cnt", 32'(cnt), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("held_cnt", 32'(cnt), 32'd0);
    key = 1'b0;
    repeat (2) @(negedge clk);
    press(4'h3);
    chk("rearm_dig", 32'(dig), 32'h0003);
    chk("rearm_cnt", 32'(cnt), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
